wb_writer: RTL and testbench

- Write-side front end for the general register file.
- Merges two writeback sources onto the file's single write port (address, data, writeback PC):
  - the in-order pipeline writeback, which is never back-pressured;
  - the long-latency multiply/divide unit, which uses a valid/ready handshake and a small result queue.
- Enforces last-writer-wins ordering between the two sources.
- Drives a stall request and a pending-write query to the hazard unit.

---
 rtl/wb_writer.sv | 163 ++++++++++++++++
 tb/tb_wb_writer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_writer.sv
// wb_writer: write-side front end for the general register file.
//
// Merges the in-order pipeline writeback (never back-pressured, always wins)
// and the multiply/divide unit result stream (valid/ready into a small
// circular queue) onto the register file's single registered write port.
// A pipeline write kills older queued entries to the same register, so the
// most recent writer wins.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   p_addr/p_data/p_pc  pipeline writeback (p_addr[4:0]==0 means no write)
//   m_valid/m_ready     MDU result handshake
//   m_addr/m_data/m_pc  MDU result payload
//   qa, q_busy          hazard query: a live queued entry targets qa[4:0]
//   stall               request a pipeline writeback bubble
//   count               entries held in the queue (live + killed)
//   wa/wd/wpc           registered register-file write port
module wb_writer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               p_addr,
    input  logic [31:0]              p_data,
    input  logic [31:0]              p_pc,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic [5:0]               m_addr,
    input  logic [31:0]              m_data,
    input  logic [31:0]              m_pc,
    input  logic [5:0]               qa,
    output logic                     q_busy,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   count,
    output logic [5:0]               wa,
    output logic [31:0]              wd,
    output logic [31:0]              wpc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned AW = $clog2(STARVE_MAX + 1);

    logic [5:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] kill_q;
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    age_q, age_d;
    logic [5:0]       wa_q, wa_d;
    logic [31:0]      wd_q, wd_d;
    logic [31:0]      wpc_q, wpc_d;

    logic p_wr, empty, push, pop;

    assign p_wr    = (p_addr[4:0] != 5'd0);
    assign empty   = (count_q == '0);
    // Ready uses only the registered count: a same-cycle pop gives no credit.
    assign m_ready = (count_q < CW'(DEPTH));
    assign push    = m_valid && m_ready;

    // Write-port selection. Killed heads and zero-address heads are popped
    // without producing a write; wd/wpc hold whenever no write is emitted.
    always_comb begin
        pop   = 1'b0;
        wa_d  = '0;
        wd_d  = wd_q;
        wpc_d = wpc_q;
        if (p_wr) begin
            wa_d  = p_addr;
            wd_d  = p_data;
            wpc_d = p_pc;
        end else if (!empty) begin
            pop = 1'b1;
            if (!kill_q[head_q] && (addr_q[head_q][4:0] != 5'd0)) begin
                wa_d  = addr_q[head_q];
                wd_d  = data_q[head_q];
                wpc_d = pc_q[head_q];
            end
        end
    end

    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
        if (empty || pop) begin
            age_d = '0;
        end else if (age_q < AW'(STARVE_MAX)) begin
            age_d = age_q + AW'(1);
        end else begin
            age_d = age_q;
        end
    end

    // The same-cycle push lands in a slot that is not yet valid, so it is
    // naturally excluded from the busy query.
    always_comb begin
        q_busy = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[PW'(i)] && !kill_q[PW'(i)] && (qa[4:0] != 5'd0) &&
                (addr_q[PW'(i)][4:0] == qa[4:0])) begin
                q_busy = 1'b1;
            end
        end
    end

    assign stall = (count_q == CW'(DEPTH)) || (age_q >= AW'(STARVE_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[PW'(i)] <= '0;
                data_q[PW'(i)] <= '0;
                pc_q[PW'(i)]   <= '0;
            end
            valid_q <= '0;
            kill_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            age_q   <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            wpc_q   <= '0;
        end else begin
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            wpc_q   <= wpc_d;
            count_q <= count_d;
            age_q   <= age_d;
            // Kill only entries present at cycle start; the push below
            // targets a slot that was invalid and clears its kill flag.
            if (p_wr) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (valid_q[PW'(i)] && (addr_q[PW'(i)][4:0] == p_addr[4:0])) begin
                        kill_q[PW'(i)] <= 1'b1;
                    end
                end
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                kill_q[head_q]  <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            if (push) begin
                addr_q[tail_q]  <= m_addr;
                data_q[tail_q]  <= m_data;
                pc_q[tail_q]    <= m_pc;
                valid_q[tail_q] <= 1'b1;
                kill_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + PW'(1);
            end
        end
    end

    assign count = count_q;
    assign wa    = wa_q;
    assign wd    = wd_q;
    assign wpc   = wpc_q;

endmodule

// File: tb/tb_wb_writer.sv
// Testbench for wb_writer: directed scenarios plus a randomized stream,
// checked every cycle against a queue-of-transactions reference model.
module tb_wb_writer;

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned STARVE_MAX = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  p_addr = '0;
    logic [31:0] p_data = '0;
    logic [31:0] p_pc = '0;
    logic        m_valid = 1'b0;
    logic        m_ready;
    logic [5:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_pc = '0;
    logic [5:0]  qa = '0;
    logic        q_busy;
    logic        stall;
    logic [2:0]  count;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [31:0] wpc;

    wb_writer #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .p_addr(p_addr), .p_data(p_data), .p_pc(p_pc),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_addr(m_addr), .m_data(m_data), .m_pc(m_pc),
        .qa(qa), .q_busy(q_busy), .stall(stall), .count(count),
        .wa(wa), .wd(wd), .wpc(wpc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
        logic [31:0] p;
        bit          k;
    } ent_t;

    ent_t        mq[$];
    int          age_m = 0;
    logic [5:0]  wa_e = '0;
    logic [31:0] wd_e = '0;
    logic [31:0] wpc_e = '0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_busy(input logic [5:0] q);
        if (q[4:0] == 5'd0) return 1'b0;
        foreach (mq[i]) if (!mq[i].k && mq[i].a[4:0] == q[4:0]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_stall();
        return (mq.size() == DEPTH) || (age_m >= STARVE_MAX);
    endfunction

    // One clock cycle: drive inputs, check combinational outputs, advance the
    // model, then check the registered write port after the edge.
    task automatic cycle(input logic [5:0] pa, input logic [31:0] pd, input logic [31:0] pp,
                         input logic mv, input logic [5:0] ma, input logic [31:0] md,
                         input logic [31:0] mp, input logic [5:0] q, output bit acc);
        bit   rdy, popped, was_empty;
        ent_t h;
        @(negedge clk);
        p_addr = pa; p_data = pd; p_pc = pp;
        m_valid = mv; m_addr = ma; m_data = md; m_pc = mp; qa = q;
        #1;
        rdy = (mq.size() < DEPTH);
        chk("m_ready", 32'(m_ready), 32'(rdy));
        chk("stall", 32'(stall), 32'(model_stall()));
        chk("q_busy", 32'(q_busy), 32'(model_busy(q)));
        chk("count", 32'(count), 32'(mq.size()));
        acc = mv && rdy;
        popped = 1'b0;
        was_empty = (mq.size() == 0);
        if (pa[4:0] != 5'd0) begin
            wa_e = pa; wd_e = pd; wpc_e = pp;
            foreach (mq[i]) if (mq[i].a[4:0] == pa[4:0]) mq[i].k = 1'b1;
        end else if (!was_empty) begin
            h = mq.pop_front();
            popped = 1'b1;
            if (!h.k && h.a[4:0] != 5'd0) begin
                wa_e = h.a; wd_e = h.d; wpc_e = h.p;
            end else begin
                wa_e = '0;
            end
        end else begin
            wa_e = '0;
        end
        if (was_empty || popped) age_m = 0;
        else if (age_m < STARVE_MAX) age_m++;
        if (acc) mq.push_back('{a: ma, d: md, p: mp, k: 1'b0});
        @(posedge clk);
        #1;
        chk("wa", 32'(wa), 32'(wa_e));
        chk("wd", wd, wd_e);
        chk("wpc", wpc, wpc_e);
    endtask

    task automatic idle(input int n, input logic [5:0] q);
        bit acc;
        for (int i = 0; i < n; i++) cycle('0, '0, '0, 1'b0, '0, '0, '0, q, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        p_addr = '0; m_valid = 1'b0; qa = '0;
        #1;
        mq.delete();
        age_m = 0; wa_e = '0; wd_e = '0; wpc_e = '0;
        chk("rst_wa", 32'(wa), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_m_ready", 32'(m_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit          acc;
        logic [5:0]  ha, pa;
        logic [31:0] hd, hp;
        bit          hv;

        do_reset();

        // Latency: push at t, visible on wa at t+2.
        cycle('0, '0, '0, 1'b1, 6'd5, 32'h1234, 32'h3008, '0, acc);
        idle(2, 6'd5);

        // Priority / full: pipeline writes r3 while four results are pushed.
        for (int i = 0; i < 4; i++)
            cycle(6'd3, 32'h300 + 32'(i), 32'h1000 + 32'(4*i), 1'b1,
                  6'(10 + i), 32'hA0 + 32'(i), 32'h2000 + 32'(4*i), 6'd11, acc);
        // Held MDU request while full; pipeline still wins.
        cycle(6'd3, 32'h3FF, 32'h1100, 1'b1, 6'd20, 32'hC0, 32'h2100, 6'd12, acc);
        for (int i = 0; i < 4 && !acc; i++)
            cycle('0, '0, '0, 1'b1, 6'd20, 32'hC0, 32'h2100, 6'd13, acc);
        chk("held_push_accepted", 32'(acc), 32'd1);
        idle(6, '0);

        // Kill: queued r7 superseded by pipeline r7.
        cycle('0, '0, '0, 1'b1, 6'd7, 32'hAAAA, 32'h4000, 6'd7, acc);
        cycle(6'd7, 32'hBBBB, 32'h4004, 1'b0, '0, '0, '0, 6'd7, acc);
        idle(3, 6'd7);

        // Same-cycle push survives the kill.
        cycle(6'd9, 32'h99, 32'h5000, 1'b1, 6'd9, 32'h55, 32'h5004, 6'd9, acc);
        idle(3, 6'd9);

        // Starvation: pipeline writes r1..r8 back to back.
        cycle('0, '0, '0, 1'b1, 6'd12, 32'h777, 32'h6000, '0, acc);
        for (int r = 1; r <= 8; r++)
            cycle(6'(r), 32'(r), 32'h6100 + 32'(r), 1'b0, '0, '0, '0, 6'd12, acc);
        cycle(6'd1, 32'h11, 32'h6200, 1'b0, '0, '0, '0, 6'd12, acc);
        idle(2, 6'd12);

        // Reset mid-stream with three queued entries.
        for (int i = 0; i < 3; i++)
            cycle(6'd3, 32'h33, 32'h7000, 1'b1, 6'(4 + i), 32'hD0 + 32'(i), 32'h7100, '0, acc);
        do_reset();
        idle(3, 6'd4);

        // Randomized stream; the MDU holds its payload until accepted.
        hv = 1'b0; ha = '0; hd = '0; hp = '0;
        for (int n = 0; n < 600; n++) begin
            if (!hv) begin
                hv = ($urandom_range(0, 99) < 55);
                ha = 6'($urandom_range(0, 63)) & 6'h27;
                hd = $urandom;
                hp = $urandom;
            end
            if ($urandom_range(0, 99) < (model_stall() ? 10 : 40))
                pa = 6'($urandom_range(0, 63)) & 6'h27;
            else
                pa = '0;
            cycle(pa, $urandom, $urandom, hv, ha, hd, hp,
                  6'($urandom_range(0, 63)) & 6'h27, acc);
            if (acc) hv = 1'b0;
            if (n == 300) do_reset();
        end
        idle(8, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
